// File: rtl/fd_decode_stage.sv
// Fetch/decode pipeline register with a 2-entry skid buffer and fixed-field instruction split.
// Optional macro FD_NOP_SQUASH_EN: accepted all-zero instructions are consumed but never stored.
module fd_decode_stage #(
   parameter int INSN_W = 32,
   parameter int PC_W   = 32,
   parameter int IMM_W  = 17
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INSN_W-1:0] in_insn,
   input  logic [PC_W-1:0]   in_pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [4:0]        out_opcode,
   output logic [4:0]        out_rd,
   output logic [4:0]        out_rs,
   output logic [4:0]        out_rt,
   output logic [4:0]        out_shamt,
   output logic [4:0]        out_aluop,
   output logic [IMM_W-1:0]  out_imm,
   output logic [26:0]       out_target,
   output logic              out_is_itype
);

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

   state_t            state, state_nxt;
   logic [INSN_W-1:0] main_insn, skid_insn;
   logic [PC_W-1:0]   main_pc, skid_pc;
   logic              main_itype;
   logic              accept, fire, store_in;
   logic              load_in, load_skid, load_from_skid;

   function automatic logic is_itype(input logic [4:0] op);
      return op inside {5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110};
   endfunction

   // Occupancy control; flush overrides everything but a coincident fire still counts downstream.
   always_comb begin
      accept         = in_valid && in_ready;
      fire           = out_valid && out_ready;
`ifdef FD_NOP_SQUASH_EN
      store_in       = accept && (in_insn != '0);
`else
      store_in       = accept;
`endif
      state_nxt      = state;
      load_in        = 1'b0;
      load_skid      = 1'b0;
      load_from_skid = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (store_in) begin
                  state_nxt = ST_ONE;
                  load_in   = 1'b1;
               end
            end
            ST_ONE: begin
               if (store_in && fire) begin
                  load_in = 1'b1;
               end else if (store_in) begin
                  state_nxt = ST_TWO;
                  load_skid = 1'b1;
               end else if (fire) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (fire) begin
                  state_nxt      = ST_ONE;
                  load_from_skid = 1'b1;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   // in_ready and out_valid are registered copies of the next occupancy, so neither depends on out_ready combinationally.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= ST_EMPTY;
         out_valid  <= 1'b0;
         in_ready   <= 1'b1;
         main_insn  <= '0;
         main_pc    <= '0;
         main_itype <= 1'b0;
         skid_insn  <= '0;
         skid_pc    <= '0;
      end else begin
         state     <= state_nxt;
         out_valid <= (state_nxt != ST_EMPTY);
         in_ready  <= (state_nxt != ST_TWO);
         if (load_in) begin
            main_insn  <= in_insn;
            main_pc    <= in_pc;
            main_itype <= is_itype(in_insn[31:27]);
         end else if (load_from_skid) begin
            main_insn  <= skid_insn;
            main_pc    <= skid_pc;
            main_itype <= is_itype(skid_insn[31:27]);
         end
         if (flush) begin
            skid_insn <= '0;
            skid_pc   <= '0;
         end else if (load_skid) begin
            skid_insn <= in_insn;
            skid_pc   <= in_pc;
         end
      end
   end

   assign out_pc       = main_pc;
   assign out_opcode   = main_insn[31:27];
   assign out_rd       = main_insn[26:22];
   assign out_rs       = main_insn[21:17];
   assign out_rt       = main_insn[16:12];
   assign out_shamt    = main_insn[11:7];
   assign out_aluop    = main_insn[6:2];
   assign out_imm      = main_insn[IMM_W-1:0];
   assign out_target   = main_insn[26:0];
   assign out_is_itype = main_itype;

endmodule

// File: tb/tb_fd_decode_stage.sv
// Self-checking bench for fd_decode_stage: directed vector table, then random traffic against a queue model.
module tb_fd_decode_stage;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_insn;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [4:0]  out_opcode, out_rd, out_rs, out_rt, out_shamt, out_aluop;
   logic [16:0] out_imm;
   logic [26:0] out_target;
   logic        out_is_itype;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   fd_decode_stage dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
      .out_shamt(out_shamt), .out_aluop(out_aluop), .out_imm(out_imm),
      .out_target(out_target), .out_is_itype(out_is_itype)
   );

   typedef struct {
      logic        iv;
      logic [31:0] insn;
      logic [31:0] pc;
      logic        ordy;
      logic        fl;
      logic        ev;
      logic        er;
      logic [31:0] epc;
      logic [31:0] einsn;
   } vec_t;

   typedef struct {
      logic [31:0] insn;
      logic [31:0] pc;
   } entry_t;

`ifdef FD_NOP_SQUASH_EN
   localparam bit SQUASH = 1'b1;
`else
   localparam bit SQUASH = 1'b0;
`endif

   localparam logic [31:0] INS_A = 32'h28C4_0005;
   localparam logic [31:0] INS_N = 32'h0000_0000;
   localparam logic [31:0] INS_B = 32'h4000_0001;
   localparam logic [31:0] INS_C = 32'h0042_2018;
   localparam logic [31:0] INS_D = 32'h1000_0020;
   localparam logic [31:0] INS_E = 32'h4001_FFFF;

   vec_t   vecs[16];
   entry_t model_q[$];

   function automatic logic [31:0] field(input logic [31:0] insn, input int lsb, input int width);
      return (insn >> lsb) & ((32'd1 << width) - 32'd1);
   endfunction

   function automatic logic [31:0] itype_of(input logic [31:0] insn);
      logic [31:0] op;
      op = insn >> 27;
      return (op == 5 || op == 7 || op == 8 || op == 2 || op == 6) ? 32'd1 : 32'd0;
   endfunction

   function automatic vec_t mk(input logic iv, input logic [31:0] insn, input logic [31:0] pc,
                               input logic ordy, input logic fl, input logic ev, input logic er,
                               input logic [31:0] epc, input logic [31:0] einsn);
      vec_t v;
      v.iv = iv; v.insn = insn; v.pc = pc; v.ordy = ordy; v.fl = fl;
      v.ev = ev; v.er = er; v.epc = epc; v.einsn = einsn;
      return v;
   endfunction

   task automatic applyStimulus(input logic iv, input logic [31:0] insn, input logic [31:0] pc,
                                input logic ordy, input logic fl);
      in_valid  = iv;
      in_insn   = insn;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkFields(input string tag, input logic [31:0] insn, input logic [31:0] pc);
      checkOutput({tag, ".pc"},     out_pc,                 pc);
      checkOutput({tag, ".opcode"}, {27'd0, out_opcode},    field(insn, 27, 5));
      checkOutput({tag, ".rd"},     {27'd0, out_rd},        field(insn, 22, 5));
      checkOutput({tag, ".rs"},     {27'd0, out_rs},        field(insn, 17, 5));
      checkOutput({tag, ".rt"},     {27'd0, out_rt},        field(insn, 12, 5));
      checkOutput({tag, ".shamt"},  {27'd0, out_shamt},     field(insn, 7, 5));
      checkOutput({tag, ".aluop"},  {27'd0, out_aluop},     field(insn, 2, 5));
      checkOutput({tag, ".imm"},    {15'd0, out_imm},       field(insn, 0, 17));
      checkOutput({tag, ".target"}, {5'd0, out_target},     field(insn, 0, 27));
      checkOutput({tag, ".itype"},  {31'd0, out_is_itype},  itype_of(insn));
   endtask

   initial begin
      logic [31:0] pc_ctr;
      logic        iv, ordy, fl, fire, acc;
      logic [31:0] insn;
      entry_t      e;

      applyStimulus(1'b1, INS_A, 32'h10, 1'b1, 1'b0);
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset.out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset.in_ready",  {31'd0, in_ready},  32'd1);
      checkFields("reset", 32'd0, 32'd0);
      @(negedge clock);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("post_reset.out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("post_reset.in_ready",  {31'd0, in_ready},  32'd1);

      // Each row: inputs held for one cycle, expected outputs just after that edge.
      vecs[0]  = mk(1, INS_A, 32'h10, 1, 0, 1, 1, 32'h10, INS_A);
      vecs[1]  = mk(1, INS_N, 32'h14, 1, 0, !SQUASH, 1, 32'h14, INS_N);
      vecs[2]  = mk(0, 32'd0, 32'h0,  1, 0, 0, 1, 32'h0,  32'd0);
      vecs[3]  = mk(1, INS_B, 32'h20, 0, 0, 1, 1, 32'h20, INS_B);
      vecs[4]  = mk(1, INS_C, 32'h24, 0, 0, 1, 0, 32'h20, INS_B);
      vecs[5]  = mk(1, INS_D, 32'h28, 0, 0, 1, 0, 32'h20, INS_B);
      vecs[6]  = mk(1, INS_D, 32'h28, 1, 0, 1, 1, 32'h24, INS_C);
      vecs[7]  = mk(1, INS_D, 32'h28, 1, 0, 1, 1, 32'h28, INS_D);
      vecs[8]  = mk(0, 32'd0, 32'h0,  1, 0, 0, 1, 32'h0,  32'd0);
      vecs[9]  = mk(1, INS_B, 32'h20, 0, 0, 1, 1, 32'h20, INS_B);
      vecs[10] = mk(1, INS_C, 32'h24, 0, 0, 1, 0, 32'h20, INS_B);
      vecs[11] = mk(1, INS_D, 32'h28, 0, 1, 0, 1, 32'h0,  32'd0);
      vecs[12] = mk(0, 32'd0, 32'h0,  1, 0, 0, 1, 32'h0,  32'd0);
      vecs[13] = mk(1, INS_A, 32'h10, 1, 1, 0, 1, 32'h0,  32'd0);
      vecs[14] = mk(1, INS_E, 32'h30, 0, 0, 1, 1, 32'h30, INS_E);
      vecs[15] = mk(0, 32'd0, 32'h0,  1, 0, 0, 1, 32'h0,  32'd0);

      foreach (vecs[i]) begin
         @(negedge clock);
         applyStimulus(vecs[i].iv, vecs[i].insn, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
         @(posedge clock);
         #1;
         checkOutput($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
         checkOutput($sformatf("vec%0d.in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].er});
         if (vecs[i].ev)
            checkFields($sformatf("vec%0d", i), vecs[i].einsn, vecs[i].epc);
      end

      // Random traffic: the model is just the ordered list of instructions the stage holds.
      model_q.delete();
      pc_ctr = 32'h1000;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clock);
         checkOutput("rand.out_valid", {31'd0, out_valid}, (model_q.size() > 0) ? 32'd1 : 32'd0);
         checkOutput("rand.in_ready",  {31'd0, in_ready},  (model_q.size() < 2) ? 32'd1 : 32'd0);
         if (model_q.size() > 0)
            checkFields("rand", model_q[0].insn, model_q[0].pc);
         iv     = ($urandom_range(0, 3) != 0);
         insn   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         ordy   = ($urandom_range(0, 2) != 0);
         fl     = ($urandom_range(0, 19) == 0);
         pc_ctr = pc_ctr + 32'd4;
         applyStimulus(iv, insn, pc_ctr, ordy, fl);
         fire = (model_q.size() > 0) && ordy;
         acc  = (model_q.size() < 2) && iv;
         if (fl) begin
            model_q.delete();
         end else begin
            if (fire)
               void'(model_q.pop_front());
            if (acc && !(SQUASH && insn == 32'd0)) begin
               e.insn = insn;
               e.pc   = pc_ctr;
               model_q.push_back(e);
            end
         end
      end

      // Reset while the stage is full must discard both entries.
      @(negedge clock);
      applyStimulus(1'b1, INS_B, 32'h40, 1'b0, 1'b0);
      @(negedge clock);
      applyStimulus(1'b1, INS_C, 32'h44, 1'b0, 1'b0);
      @(negedge clock);
      applyStimulus(1'b1, INS_D, 32'h48, 1'b1, 1'b0);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("midreset.out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("midreset.in_ready",  {31'd0, in_ready},  32'd1);
      checkFields("midreset", 32'd0, 32'd0);
      @(negedge clock);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("after_midreset.out_valid", {31'd0, out_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fd_decode_stage.md
Name: fd_decode_stage

Overview:
- Fetch/decode pipeline register with a 2-entry skid buffer between instruction fetch and the decode datapath.
- Accepts 32-bit instructions and their PCs over a valid/ready handshake and splits them into register, ALU and 17-bit immediate fields.
- out_imm drives the downstream 17-to-32 sign extender directly; no extension is done here.
- Supports pipeline flush on taken branch/jump.

Parameters:
- INSN_W, 32, instruction width; field map is fixed for 32.
- PC_W, 32, program counter width.
- IMM_W, 17, immediate field width; must equal the sign-extender input width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept
- in_insn  in  INSN_W  instruction word
- in_pc  in  PC_W  PC of in_insn
- flush  in  1  discard all held instructions
- out_valid  out  1  decoded instruction present
- out_ready  in  1  downstream consumes
- out_pc  out  PC_W  PC of presented instruction
- out_opcode  out  5  insn[31:27]
- out_rd  out  5  insn[26:22]
- out_rs  out  5  insn[21:17]
- out_rt  out  5  insn[16:12]
- out_shamt  out  5  insn[11:7]
- out_aluop  out  5  insn[6:2]
- out_imm  out  IMM_W  insn[16:0], unextended
- out_target  out  27  insn[26:0]
- out_is_itype  out  1  opcode in {00101 addi, 00111 sw, 01000 lw, 00010 bne, 00110 blt}

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low on reset_n, sampled at the clock edge.
- Reset values: state EMPTY, out_valid=0, in_ready=1, all out_* data fields=0, skid entry cleared.
- Transfer rules:
  - Accept = in_valid && in_ready.
  - Fire = out_valid && out_ready.
  - All output fields are registered and decoded from the main entry.
- Latency: an instruction accepted in cycle N appears with out_valid=1 in cycle N+1 when the stage was EMPTY or firing.
- State EMPTY: in_ready=1, out_valid=0. Accept -> ONE.
- State ONE (main entry valid, skid empty): in_ready=1.
  - Accept and fire -> ONE, main loaded with the new instruction.
  - Accept, no fire -> TWO, new instruction stored in skid.
  - Fire, no accept -> EMPTY.
  - Neither -> ONE, hold.
- State TWO: in_ready=0.
  - Fire -> ONE, main <= skid.
  - Otherwise hold.
- in_ready is a registered output: 1 in EMPTY and ONE, 0 in TWO. There is no combinational path from out_ready.
- Stability: while out_valid && !out_ready, all out_* fields hold bit-for-bit.
- Flush priority: flush has priority over every other event. Next state is EMPTY, out_valid=0 the following cycle, skid cleared.
  - An instruction offered in the same cycle is dropped even though in_ready=1.
  - Data fields may keep stale values while out_valid=0.
- Fire coincident with flush: downstream consumes the presented instruction normally. Flush affects only the next state.
- Field extraction: pure bit selection, no arithmetic. Overlapping fields (rt/imm, rd/target) are all driven simultaneously.
- out_is_itype is registered with the other fields. It is 0 for all other opcodes, including 00000 (R-type).
- Reset mid-operation: both entries discarded and reset values applied next cycle, regardless of the handshake state.
- Ordering: instructions leave in acceptance order. No instruction is duplicated or lost except by flush or reset.

Optional Feature:
- Macro: FD_NOP_SQUASH_EN.
- Defined:
  - An accepted instruction equal to 32'h00000000 is consumed (in_ready unaffected) but never stored. State and out_valid behave as if no accept happened.
  - A nop arriving while in ONE with fire gives next state EMPTY.
- Undefined: nop is treated as an ordinary instruction and presented downstream.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1 and all fields 0 after release. Nothing accepted during reset.
- Streaming: out_ready=1; feed insn 32'h28C4_0005 (addi rd=3 rs=2 imm=5) then 32'h0000_0000 at PC 0x10 and 0x14 -> one cycle later out_opcode=5'b00101, out_rd=3, out_rs=2, out_imm=17'h00005, out_is_itype=1, out_pc=0x10. Next cycle the nop (macro off) appears with out_pc=0x14.
- Backpressure: out_ready=0; offer 3 instructions -> first two accepted, in_ready=0 after the second, outputs frozen. Raise out_ready -> all three emerge in order with no drop or duplicate.
- Negative immediate: insn with imm=17'h1FFFF (opcode 01000 lw) -> out_imm=17'h1FFFF, out_is_itype=1. out_rt shows insn[16:12]=5'h1F simultaneously.
- Flush: in TWO state, assert flush together with in_valid=1 -> next cycle out_valid=0, state EMPTY, in_ready=1. The offered instruction never appears.
- FD_NOP_SQUASH_EN defined: stream add, nop, add -> only the two adds appear on consecutive fire cycles; nop never raises out_valid.
